qupls4_wp_history: RTL and testbench
====================================

# qupls4_wp_history

Register-file write-port history buffer for the Qupls4 scheduler. It captures every physical-register write presented to the register file each cycle and keeps it for `DEPTH` cycles in a shift structure. The operand validation stage can then match waiting operands against recently written values that the register file read ports do not yet reflect. It sits beside the register file write ports and directly feeds the `wp_hist` input of the operand validation stage.

## Interface
Parameters:
- `MWIDTH`, 4: write ports captured per cycle.
- `DEPTH`, 5: history depth in cycles; the output is indexed `[0:DEPTH-1]`.
- `NFREE`, 4: physical-register free notifications per cycle.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `wp_i` in `MWIDTH` × `Qupls4_pkg::operand_t`: register-file write ports this cycle; fields used are `pRn`, `v`, `val`, `flags`.
- `free_i` in `NFREE` × `cpu_types_pkg::pregno_t`: physical registers being returned to the free list.
- `free_v_i` in `NFREE`: per-slot valid for `free_i`.
- `hist_o` out `[0:DEPTH-1]` × `MWIDTH` × `operand_t`: history.
  - Row 0 holds the newest writes; row `DEPTH-1` holds the oldest.
  - Driven directly from flops.
- `hist_cnt_o` out `$clog2(DEPTH*MWIDTH+1)`: number of entries with `v=1`. Combinational from the history flops.

## Operation
- **Capture.** Each cycle, row 0 loads `wp_i`, and for d ≥ 1 row d loads row d-1. The contents of row `DEPTH-1` are discarded. The history advances every cycle; there is no stall input, because a write that has occurred is a fact regardless of pipeline stalls.
- **Filtered inputs.** A port with `v=0`, or with `pRn==0`, is stored as an invalid entry. `pRn` 0 is the hard-zero register and its operands are satisfied by the `z` field.
- **Invalid entries.** Every invalid entry is stored all-zero: `pRn=0`, `val=0`, `flags=0`, `v=0`. The validation stage therefore never sees stale `pRn` or `val` values.
- **Supersession (older rows).** When an incoming valid port writes register P, every entry shifting into rows 1..`DEPTH-1` with `pRn==P` is cleared. At most one valid copy of any `pRn` exists at any time.
- **Supersession (same cycle).** If two valid `wp_i` ports carry the same `pRn`, the higher port index is kept and the lower one is cleared.
- **Free invalidation.** Any entry whose `pRn` matches a valid `free_i` slot is cleared as it is written. This applies to both the incoming row 0 and shifted rows. It prevents a reallocated physical register from matching a value written under its previous mapping.
- **Priority.** Free invalidation beats capture: a write and a free of the same `pRn` in the same cycle leaves no valid copy.
- **Single register stage.** All supersession and free checks are applied to the next-state values, so they take effect in the same register stage as the capture.
- **Count.** `hist_cnt_o` is the popcount of `v` across all `DEPTH*MWIDTH` entries.
- **Reset.** Asserting `rst` at any time, including mid-stream, clears every entry to all-zero immediately (asynchronously). `hist_cnt_o` reads 0 while reset is asserted. Capture resumes on the first rising edge after `rst` deasserts.

## Timing
- A write presented on `wp_i` in cycle N:
  - appears in `hist_o[0]` in cycle N+1;
  - appears in `hist_o[d]` in cycle N+1+d;
  - is absent from cycle N+1+`DEPTH` onward.
- A supersession or free in cycle M is visible in `hist_o` from cycle M+1.
- No combinational path from `wp_i`, `free_i` or `free_v_i` to `hist_o`.
- `hist_cnt_o` settles in the same cycle as the `hist_o` flop outputs.
- Reset value of every output: all zero.

## Test plan
- **Reset, then a single write.** After reset, drive `wp_i[2]={pRn=37,val=0x1234,v=1}` for one cycle.
  - The entry is seen at `hist_o[0][2]`, then `[1][2]` … `[4][2]` over cycles N+1..N+5.
  - In every slot it appears it carries `val=0x1234` and `v=1`.
  - It is all-zero at N+6.
  - `hist_cnt_o` is 1 for cycles N+1..N+5 and 0 otherwise.
- **Full occupancy.** Drive 4 distinct valid nonzero `pRn` every cycle for 6 cycles.
  - `hist_cnt_o` reads 4, 8, 12, 16, 20, then holds at 20.
  - The oldest row is dropped each cycle.
- **Supersession.**
  - Write `pRn 50, val=1` in cycle N and `pRn 50, val=2` in cycle N+2 on a different port.
  - At N+3, `hist_o[0]` holds `val=2` and the N entry (then in row 2) is cleared; `hist_cnt_o=1`.
  - Same-cycle case: ports 0 and 3 both write `pRn 9`; only port 3 is valid in row 0.
- **Free.**
  - Write `pRn 12` in cycle N, then assert `free_i[1]=12, free_v_i[1]=1` in N+2. The entry is cleared at N+3.
  - A simultaneous write and free of `pRn 7` leaves no valid entry.
- **Filtering.** Valid write with `pRn=0`, and `v=0` writes with nonzero `pRn` -> every captured entry all-zero; `hist_cnt_o` stays 0.
- **Reset mid-stream.** With 12 valid entries, pulse `rst` between clock edges -> `hist_o` is all-zero and `hist_cnt_o=0` immediately; writes after deassertion are captured normally.

Source files
------------

// File: rtl/qupls4_wp_history.sv
// Register-file write-port history: keeps every physical-register write for DEPTH cycles.
// Latency: a write in cycle N is in hist_o[d] in cycle N+1+d; hist_cnt_o follows the flops combinationally.
// Backpressure: none. The history advances every cycle, because a write that happened is a fact.
//
// Ports:
//   clk, rst    - clock and asynchronous active-high reset (clears all entries immediately)
//   wp_i        - MWIDTH register-file write ports presented this cycle
//   free_i      - NFREE physical registers returning to the free list
//   free_v_i    - per-slot valid for free_i
//   hist_o      - [0:DEPTH-1] rows of MWIDTH entries; row 0 is the newest; driven from flops
//   hist_cnt_o  - number of valid entries held in hist_o

package cpu_types_pkg;
    typedef logic [8:0] pregno_t;
endpackage

package Qupls4_pkg;
    typedef struct packed {
        logic                   z;      // operand satisfied by the hard-zero register
        cpu_types_pkg::pregno_t pRn;
        logic                   v;
        logic [63:0]            val;
        logic [7:0]             flags;
    } operand_t;
endpackage

module qupls4_wp_history #(
    parameter int MWIDTH = 4,
    parameter int DEPTH  = 5,
    parameter int NFREE  = 4,
    parameter int CW     = $clog2(DEPTH*MWIDTH+1)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  Qupls4_pkg::operand_t [MWIDTH-1:0]         wp_i,
    input  cpu_types_pkg::pregno_t [NFREE-1:0]        free_i,
    input  logic [NFREE-1:0]                          free_v_i,
    output Qupls4_pkg::operand_t [MWIDTH-1:0]         hist_o [0:DEPTH-1],
    output logic [CW-1:0]                             hist_cnt_o
);
    import Qupls4_pkg::*;

    operand_t [MWIDTH-1:0] hist_nxt [0:DEPTH-1];
    logic     [MWIDTH-1:0] wr_vld;   // incoming port carries a real (nonzero pRn) write

    always_comb begin
        for (int i = 0; i < MWIDTH; i++)
            wr_vld[i] = wp_i[i].v && (wp_i[i].pRn != '0);
    end

    // Next-state for every row. All filtering happens here so supersession and
    // free invalidation land in the same register stage as the capture.
    always_comb begin
        for (int d = 0; d < DEPTH; d++)
            for (int i = 0; i < MWIDTH; i++)
                hist_nxt[d][i] = '0;

        // Row 0: new writes. A higher port writing the same register wins,
        // and a same-cycle free of the register beats the write.
        for (int i = 0; i < MWIDTH; i++) begin
            logic keep;
            keep = wr_vld[i];
            for (int j = i + 1; j < MWIDTH; j++)
                if (wr_vld[j] && (wp_i[j].pRn == wp_i[i].pRn))
                    keep = 1'b0;
            for (int f = 0; f < NFREE; f++)
                if (free_v_i[f] && (free_i[f] == wp_i[i].pRn))
                    keep = 1'b0;
            if (keep)
                hist_nxt[0][i] = wp_i[i];
        end

        // Rows 1..DEPTH-1: shift, dropping anything rewritten or freed this cycle.
        // Invalid entries are always all-zero, so only valid ones need checking.
        for (int d = 1; d < DEPTH; d++) begin
            for (int i = 0; i < MWIDTH; i++) begin
                logic keep;
                keep = hist_o[d-1][i].v;
                for (int j = 0; j < MWIDTH; j++)
                    if (wr_vld[j] && (wp_i[j].pRn == hist_o[d-1][i].pRn))
                        keep = 1'b0;
                for (int f = 0; f < NFREE; f++)
                    if (free_v_i[f] && (free_i[f] == hist_o[d-1][i].pRn))
                        keep = 1'b0;
                if (keep)
                    hist_nxt[d][i] = hist_o[d-1][i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < DEPTH; d++)
                hist_o[d] <= '0;
        end else begin
            for (int d = 0; d < DEPTH; d++)
                hist_o[d] <= hist_nxt[d];
        end
    end

    always_comb begin
        hist_cnt_o = '0;
        for (int d = 0; d < DEPTH; d++)
            for (int i = 0; i < MWIDTH; i++)
                hist_cnt_o = hist_cnt_o + CW'(hist_o[d][i].v);
    end

endmodule

// File: tb/tb_qupls4_wp_history.sv
// Directed bench for qupls4_wp_history: reset, shifting, occupancy, supersession,
// free invalidation, input filtering and asynchronous mid-stream reset.
// Outputs are sampled 1 time unit after each rising edge.
module tb_qupls4_wp_history;
    import Qupls4_pkg::*;

    logic                                clk;
    logic                                rst;
    operand_t [3:0]                      wp;
    cpu_types_pkg::pregno_t [3:0]        fr;
    logic [3:0]                          fr_v;
    operand_t [3:0]                      hist [0:4];
    logic [4:0]                          cnt;

    int checks = 0;
    int errors = 0;

    qupls4_wp_history #(.MWIDTH(4), .DEPTH(5), .NFREE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wp_i       (wp),
        .free_i     (fr),
        .free_v_i   (fr_v),
        .hist_o     (hist),
        .hist_cnt_o (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic operand_t op(input logic [8:0] p, input logic [63:0] val, input logic vv);
        operand_t o;
        o       = '0;
        o.pRn   = p;
        o.val   = val;
        o.v     = vv;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_op(input string tag, input operand_t obs, input operand_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed pRn=%0d v=%0b val=%0h expected pRn=%0d v=%0b val=%0h",
                   tag, obs.pRn, obs.v, obs.val, exp.pRn, exp.v, exp.val);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic flush();
        wp   = '0;
        fr_v = '0;
        repeat (5) tick();
    endtask

    initial begin
        rst  = 1'b1;
        wp   = '0;
        fr   = '0;
        fr_v = '0;
        #12;
        chk_cnt("reset_cnt", cnt, 5'd0);
        chk_op("reset_r0p0", hist[0][0], '0);
        chk_op("reset_r4p3", hist[4][3], '0);
        rst = 1'b0;

        // Single write on port 2 walks through all five rows, then disappears.
        wp[2] = op(9'd37, 64'h1234, 1'b1);
        tick();
        wp = '0;
        chk_op("single_r0", hist[0][2], op(9'd37, 64'h1234, 1'b1));
        chk_cnt("single_cnt0", cnt, 5'd1);
        for (int d = 1; d < 5; d++) begin
            tick();
            chk_op($sformatf("single_r%0d", d), hist[d][2], op(9'd37, 64'h1234, 1'b1));
            chk_op($sformatf("single_prev_r%0d", d - 1), hist[d-1][2], '0);
            chk_cnt($sformatf("single_cnt%0d", d), cnt, 5'd1);
        end
        tick();
        chk_op("single_gone", hist[4][2], '0);
        chk_cnt("single_cnt_end", cnt, 5'd0);

        // Full occupancy: four distinct registers each cycle for six cycles.
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 4; i++)
                wp[i] = op(9'(100 + 4*c + i), 64'(16*c + i), 1'b1);
            tick();
            chk_cnt($sformatf("full_cnt_c%0d", c), cnt, (c < 5) ? 5'(4*(c+1)) : 5'd20);
        end
        chk_op("full_r0p0", hist[0][0], op(9'd120, 64'd80, 1'b1));
        chk_op("full_r4p0", hist[4][0], op(9'd104, 64'd16, 1'b1));
        chk_op("full_r4p3", hist[4][3], op(9'd107, 64'd19, 1'b1));
        flush();
        chk_cnt("full_flushed", cnt, 5'd0);

        // Supersession across rows: pRn 50 rewritten two cycles later on another port.
        wp[0] = op(9'd50, 64'd1, 1'b1);
        tick();
        wp = '0;
        tick();
        wp[1] = op(9'd50, 64'd2, 1'b1);
        tick();
        wp = '0;
        chk_op("super_new", hist[0][1], op(9'd50, 64'd2, 1'b1));
        chk_op("super_old_cleared", hist[2][0], '0);
        chk_cnt("super_cnt", cnt, 5'd1);
        flush();

        // Same-cycle supersession: port 3 beats port 0.
        wp[0] = op(9'd9, 64'hA, 1'b1);
        wp[3] = op(9'd9, 64'hB, 1'b1);
        tick();
        wp = '0;
        chk_op("same_p0_cleared", hist[0][0], '0);
        chk_op("same_p3_kept", hist[0][3], op(9'd9, 64'hB, 1'b1));
        chk_cnt("same_cnt", cnt, 5'd1);
        flush();

        // Free of a register already in the history.
        wp[0] = op(9'd12, 64'h12, 1'b1);
        tick();
        wp = '0;
        tick();
        chk_op("free_before", hist[1][0], op(9'd12, 64'h12, 1'b1));
        fr[1]   = 9'd12;
        fr_v[1] = 1'b1;
        tick();
        fr_v = '0;
        chk_op("free_cleared", hist[2][0], '0);
        chk_cnt("free_cnt", cnt, 5'd0);

        // Write and free of the same register in one cycle leaves nothing.
        wp[2]   = op(9'd7, 64'd7, 1'b1);
        fr[0]   = 9'd7;
        fr_v[0] = 1'b1;
        tick();
        wp   = '0;
        fr_v = '0;
        chk_op("free_same_cycle", hist[0][2], '0);
        chk_cnt("free_same_cnt", cnt, 5'd0);

        // Filtering: pRn 0 with v=1, and v=0 with nonzero pRn, are stored as zero.
        wp[0] = op(9'd0,  64'h55, 1'b1);
        wp[1] = op(9'd33, 64'h66, 1'b0);
        wp[2] = op(9'd44, 64'h77, 1'b0);
        wp[3] = op(9'd0,  64'h88, 1'b0);
        tick();
        for (int i = 0; i < 4; i++)
            chk_op($sformatf("filter_p%0d", i), hist[0][i], '0);
        chk_cnt("filter_cnt", cnt, 5'd0);
        tick();
        wp = '0;
        chk_op("filter_r1p1", hist[1][1], '0);
        chk_cnt("filter_cnt2", cnt, 5'd0);
        flush();

        // Mid-stream asynchronous reset with 12 valid entries.
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 4; i++)
                wp[i] = op(9'(200 + 4*c + i), 64'(c + 1), 1'b1);
            tick();
        end
        chk_cnt("mid_cnt12", cnt, 5'd12);
        #3;
        rst = 1'b1;
        wp  = '0;
        #1;
        chk_cnt("mid_rst_cnt", cnt, 5'd0);
        chk_op("mid_rst_r0p0", hist[0][0], '0);
        chk_op("mid_rst_r2p3", hist[2][3], '0);
        #1;
        rst   = 1'b0;
        wp[1] = op(9'd60, 64'h60, 1'b1);
        tick();
        wp = '0;
        chk_op("post_rst_r0", hist[0][1], op(9'd60, 64'h60, 1'b1));
        chk_cnt("post_rst_cnt", cnt, 5'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
